cbs_result_writer: RTL

Write-side counterpart to the CBS read address generator. It accepts processed CBS output pixels over a valid/ready stream, in raster order. For each pixel it generates the feature-map write address from its own row and column counters and drives a single write port into the output feature-map memory, honouring memory backpressure. Frame start and end are signalled with start/busy/frame_done so the layer sequencer can chain layers.

---
 rtl/cbs_result_writer_if.sv | 24 ++
 rtl/cbs_result_writer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cbs_result_writer_if.sv
// Pixel input stream and feature-map write port of the CBS result writer.
// The writer connects through the slave modport; the producer/memory side uses master.
interface cbs_result_writer_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport slave (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_wr_en, mem_addr, mem_data
  );

  modport master (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_data
  );
endinterface

// File: rtl/cbs_result_writer.sv
// Raster-order CBS result writer: one-entry output register driving a feature-map write port.
// Optional macro CBS_WR_CLAMP_EN clamps negative pixels to zero on the way in.
module cbs_result_writer #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 640,
  parameter int LINE_PITCH = 640,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  cbs_result_writer_if.slave  bus,
  output logic                busy,
  output logic                frame_done,
  output logic [ADDR_W-1:0]   pix_count
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PITCH    = ADDR_W'(LINE_PITCH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic [DATA_W-1:0] pix_in;
  logic              in_acc;
  logic              wr_acc;
  logic              last_pix;

  assign bus.in_ready = (state == RUN) && (!bus.mem_wr_en || bus.mem_ready);
  assign in_acc       = bus.in_valid && bus.in_ready;
  assign wr_acc       = bus.mem_wr_en && bus.mem_ready;
  assign last_pix     = (row == ROW_LAST) && (col == COL_LAST);

`ifdef CBS_WR_CLAMP_EN
  assign pix_in = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
  assign pix_in = bus.in_data;
`endif

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (in_acc && last_pix) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (wr_acc) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Raster counters; row_base accumulates the pitch so no multiplier is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      row      <= '0;
      row_base <= BASE;
    end else if (in_acc) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row      <= '0;
          row_base <= BASE;
        end else begin
          row      <= row + ROW_W'(1);
          row_base <= row_base + PITCH;
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Output register: reloads on input accept, empties on a write accept with no reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_wr_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_data  <= '0;
    end else if (in_acc) begin
      bus.mem_wr_en <= 1'b1;
      bus.mem_addr  <= row_base + ADDR_W'(col);
      bus.mem_data  <= pix_in;
    end else if (wr_acc) begin
      bus.mem_wr_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      pix_count <= '0;
    else if (state == IDLE && start) pix_count <= '0;
    else if (wr_acc)                 pix_count <= pix_count + ADDR_W'(1);
  end

endmodule
